qspi_xip_line_buffer: RTL

QSPI_XIP_LINE_BUFFER -- requirements
Module: qspi_xip_line_buffer

---
 rtl/qspi_xip_line_buffer.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/qspi_xip_line_buffer.sv
// Single-line execute-in-place read buffer between a CPU AHB master and the qspi_master slave.
// Read misses fill the whole line word by word; writes pass straight through and invalidate a matching line.
module qspi_xip_line_buffer #(
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             sys_clk,
  input  logic             a_res_n,
  input  logic [31:0]      s_haddr,
  input  logic [2:0]       s_hsize,
  input  logic             s_hsel,
  input  logic             s_hwrite,
  input  logic [31:0]      s_hwdata,
  output logic             s_hready,
  output logic [31:0]      s_hrdata,
  output logic [31:0]      m_haddr,
  output logic [2:0]       m_hsize,
  output logic             m_hsel,
  output logic             m_hwrite,
  output logic [31:0]      m_hwdata,
  input  logic             m_hready,
  input  logic [31:0]      m_hrdata,
  input  logic             flush,
  output logic             line_valid,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  localparam int unsigned OFF_W = $clog2(LINE_WORDS * 4);
  localparam int unsigned IDX_W = $clog2(LINE_WORDS);
  localparam int unsigned TAG_W = 32 - OFF_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_WORDS - 1);

  typedef enum logic [2:0] {IDLE, FILL_REQ, FILL_WAIT, WR_REQ, WR_WAIT, RESP} state_t;

  state_t           r_state;
  logic             r_valid;
  logic [TAG_W-1:0] r_tag;
  logic [31:0]      r_data [LINE_WORDS];
  logic [IDX_W-1:0] r_idx;
  logic [31:2]      r_addr;
  logic             r_fill_flushed;
  logic             r_wd_pend;
  logic [CNT_W-1:0] r_hit_cnt;
  logic [CNT_W-1:0] r_miss_cnt;
  logic             r_s_hready;
  logic [31:0]      r_s_hrdata;
  logic             r_m_hsel;
  logic             r_m_hwrite;
  logic [31:0]      r_m_haddr;
  logic [2:0]       r_m_hsize;
  logic [31:0]      r_m_hwdata;

  logic             w_accept;
  logic             w_tag_match;
  logic             w_hit;
  logic [IDX_W-1:0] w_req_idx;
  logic [IDX_W-1:0] w_fill_req_idx;
  logic [IDX_W-1:0] w_idx_next;

  assign w_accept       = s_hsel && r_s_hready && (r_state == IDLE);
  assign w_tag_match    = r_valid && (s_haddr[31:OFF_W] == r_tag);
  assign w_hit          = w_tag_match && !s_hwrite && !flush;
  assign w_req_idx      = s_haddr[OFF_W-1:2];
  assign w_fill_req_idx = r_addr[OFF_W-1:2];
  assign w_idx_next     = r_idx + 1'b1;

  always_ff @(posedge sys_clk or negedge a_res_n) begin
    if (!a_res_n) begin
      r_state        <= IDLE;
      r_valid        <= 1'b0;
      r_tag          <= '0;
      for (int unsigned i = 0; i < LINE_WORDS; i++) r_data[i] <= '0;
      r_idx          <= '0;
      r_addr         <= '0;
      r_fill_flushed <= 1'b0;
      r_wd_pend      <= 1'b0;
      r_hit_cnt      <= '0;
      r_miss_cnt     <= '0;
      r_s_hready     <= 1'b1;
      r_s_hrdata     <= '0;
      r_m_hsel       <= 1'b0;
      r_m_hwrite     <= 1'b0;
      r_m_haddr      <= '0;
      r_m_hsize      <= '0;
      r_m_hwdata     <= '0;
    end else begin
      // Flush always drops valid; the only later write of 1 below folds flush back in.
      if (flush) r_valid <= 1'b0;
      if (flush && (r_state == FILL_REQ || r_state == FILL_WAIT)) r_fill_flushed <= 1'b1;

      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_addr <= s_haddr[31:2];
            if (s_hwrite) begin
              if (w_tag_match) r_valid <= 1'b0;
              r_state    <= WR_REQ;
              r_s_hready <= 1'b0;
              r_wd_pend  <= 1'b1;
              r_m_hsel   <= 1'b1;
              r_m_hwrite <= 1'b1;
              r_m_haddr  <= s_haddr;
              r_m_hsize  <= s_hsize;
            end else if (w_hit) begin
              r_s_hrdata <= r_data[w_req_idx];
              if (r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + 1'b1;
            end else begin
              r_valid        <= 1'b0;
              if (r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + 1'b1;
              r_idx          <= '0;
              r_fill_flushed <= 1'b0;
              r_state        <= FILL_REQ;
              r_s_hready     <= 1'b0;
              r_m_hsel       <= 1'b1;
              r_m_hwrite     <= 1'b0;
              r_m_hsize      <= 3'b010;
              r_m_haddr      <= {s_haddr[31:OFF_W], {OFF_W{1'b0}}};
              r_m_hwdata     <= '0;
            end
          end
        end
        FILL_REQ: begin
          if (m_hready) begin
            r_m_hsel <= 1'b0;
            r_state  <= FILL_WAIT;
          end
        end
        FILL_WAIT: begin
          if (m_hready) begin
            r_data[r_idx] <= m_hrdata;
            if (r_idx != LAST_IDX) begin
              r_idx     <= w_idx_next;
              r_state   <= FILL_REQ;
              r_m_hsel  <= 1'b1;
              r_m_haddr <= {r_addr[31:OFF_W], w_idx_next, 2'b00};
            end else begin
              r_tag      <= r_addr[31:OFF_W];
              r_valid    <= !(r_fill_flushed || flush);
              r_state    <= RESP;
              r_s_hready <= 1'b1;
              // The last word is still on the bus; earlier words are already in the line.
              r_s_hrdata <= (w_fill_req_idx == LAST_IDX) ? m_hrdata : r_data[w_fill_req_idx];
            end
          end
        end
        WR_REQ: begin
          if (r_wd_pend) begin
            r_m_hwdata <= s_hwdata;
            r_wd_pend  <= 1'b0;
          end
          if (m_hready) begin
            r_m_hsel <= 1'b0;
            r_state  <= WR_WAIT;
          end
        end
        WR_WAIT: begin
          if (m_hready) begin
            r_state    <= RESP;
            r_s_hready <= 1'b1;
            r_s_hrdata <= '0;
            r_m_hwdata <= '0;
            r_m_hwrite <= 1'b0;
          end
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign s_hready   = r_s_hready;
  assign s_hrdata   = r_s_hrdata;
  assign m_hsel     = r_m_hsel;
  assign m_hwrite   = r_m_hwrite;
  assign m_haddr    = r_m_haddr;
  assign m_hsize    = r_m_hsize;
  assign m_hwdata   = r_m_hwdata;
  assign line_valid = r_valid;
  assign hit_count  = r_hit_cnt;
  assign miss_count = r_miss_cnt;

endmodule
